// File: rtl/fetch_scheduler_if.sv
// Fetch-side bundle between the scheduler, i-cache, instruction queue and redirect source.
// master = scheduler side, slave = environment side.
interface fetch_scheduler_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_pc;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic [31:0] rsp_pc;
    logic        enq_valid;
    logic [31:0] enq_data;
    logic [31:0] enq_pc;
    logic        deq;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        iq_flush;
    logic        proto_err;

    modport master (
        output req_valid, req_pc, enq_valid, enq_data, enq_pc, iq_flush, proto_err,
        input  req_ready, rsp_valid, rsp_data, rsp_pc, deq, redirect_valid, redirect_pc
    );

    modport slave (
        input  req_valid, req_pc, enq_valid, enq_data, enq_pc, iq_flush, proto_err,
        output req_ready, rsp_valid, rsp_data, rsp_pc, deq, redirect_valid, redirect_pc
    );
endinterface

// File: rtl/fetch_scheduler.sv
// Credit-throttled instruction fetch sequencer: issues PCs to the i-cache, forwards
// responses into the instruction queue, and drains stale responses after a redirect.
module fetch_scheduler #(
    parameter int unsigned IQ_DEPTH     = 8,
    parameter int unsigned MAX_INFLIGHT = 4,
    parameter logic [31:0] RESET_PC     = 32'h0040_0000
) (
    input  logic            clk,
    input  logic            rst_n,
    fetch_scheduler_if.master bus
);
    localparam int unsigned OCC_W = $clog2(IQ_DEPTH) + 1;
    localparam int unsigned INF_W = $clog2(MAX_INFLIGHT) + 1;
    localparam int unsigned SUM_W = ((OCC_W > INF_W) ? OCC_W : INF_W) + 1;

    typedef enum logic {ST_RUN, ST_DRAIN} state_e;

    state_e             state_q, state_d;
    logic [31:0]        pc_q, pc_d;
    logic [31:0]        pend_q, pend_d;
    logic [OCC_W-1:0]   occ_q, occ_d;
    logic [INF_W-1:0]   inflight_q, inflight_d;
    logic               perr_q, perr_d;

    logic               issue;
    logic               accept;
    logic               enq_ok;
    logic               flush;
    logic               rsp_ok;
    logic               deq_ok;
    logic               credit_ok;
    logic               inf_room;
    logic [INF_W-1:0]   inf_after_rsp;

    // Credit: queued plus in-flight must stay below queue depth to issue.
    assign credit_ok     = (SUM_W'(occ_q) + SUM_W'(inflight_q)) < SUM_W'(IQ_DEPTH);
    assign inf_room      = inflight_q < INF_W'(MAX_INFLIGHT);
    assign rsp_ok        = bus.rsp_valid && (inflight_q != '0);
    assign deq_ok        = bus.deq && (occ_q != '0);
    assign inf_after_rsp = inflight_q - INF_W'(rsp_ok);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_RUN;
            pc_q       <= RESET_PC;
            pend_q     <= '0;
            occ_q      <= '0;
            inflight_q <= '0;
            perr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            pend_q     <= pend_d;
            occ_q      <= occ_d;
            inflight_q <= inflight_d;
            perr_q     <= perr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        pend_d     = pend_q;
        occ_d      = occ_q;
        inflight_d = inflight_q;
        perr_d     = perr_q;
        issue      = 1'b0;
        accept     = 1'b0;
        enq_ok     = 1'b0;
        flush      = 1'b0;

        if (bus.rsp_valid && (inflight_q == '0)) begin
            perr_d = 1'b1;
        end

        if (bus.redirect_valid) begin
            // Flush now; wait out any responses still owed before refetching.
            flush      = 1'b1;
            occ_d      = '0;
            inflight_d = inf_after_rsp;
            if (inf_after_rsp == '0) begin
                state_d = ST_RUN;
                pc_d    = bus.redirect_pc;
            end else begin
                state_d = ST_DRAIN;
                pend_d  = bus.redirect_pc;
            end
        end else begin
            unique case (state_q)
                ST_RUN: begin
                    issue      = credit_ok && inf_room;
                    accept     = issue && bus.req_ready;
                    enq_ok     = rsp_ok;
                    occ_d      = occ_q + OCC_W'(rsp_ok) - OCC_W'(deq_ok);
                    inflight_d = inflight_q + INF_W'(accept) - INF_W'(rsp_ok);
                    if (accept) begin
                        pc_d = pc_q + 32'd4;
                    end
                end
                ST_DRAIN: begin
                    inflight_d = inf_after_rsp;
                    if (inf_after_rsp == '0) begin
                        state_d = ST_RUN;
                        pc_d    = pend_q;
                    end
                end
                default: state_d = ST_RUN;
            endcase
        end
    end

    assign bus.req_valid = issue;
    assign bus.req_pc    = pc_q;
    assign bus.enq_valid = enq_ok;
    assign bus.enq_data  = bus.rsp_data;
    assign bus.enq_pc    = bus.rsp_pc;
    assign bus.iq_flush  = flush;
    assign bus.proto_err = perr_q;

endmodule

// File: tb/tb_fetch_scheduler.sv
// Bench for fetch_scheduler: in-order i-cache responder, queue-based reference model
// compared every cycle, plus directed scenarios with literal expectations.
module tb_fetch_scheduler;
    localparam int          DEPTH = 8;
    localparam int          MAXIF = 4;
    localparam logic [31:0] RPC   = 32'h0040_0000;
    localparam logic [31:0] KEY   = 32'hDEAD_BEEF;

    logic clk;
    logic rst_n;
    fetch_scheduler_if bus();

    fetch_scheduler #(.IQ_DEPTH(DEPTH), .MAX_INFLIGHT(MAXIF), .RESET_PC(RPC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // I-cache responder: answers each accepted request in order, one cycle later.
    logic        rsp_en    = 1'b1;
    logic        force_rsp = 1'b0;
    logic        acc_s     = 1'b0;
    logic [31:0] acc_pc    = '0;
    logic [31:0] icq[$];
    int          n_acc = 0;
    int          n_enq = 0;
    logic [31:0] last_enq_pc = '0;

    always @(negedge clk) begin
        acc_s  = rst_n && bus.req_valid && bus.req_ready;
        acc_pc = bus.req_pc;
        if (acc_s) n_acc++;
        if (rst_n && bus.enq_valid) begin
            n_enq++;
            last_enq_pc = bus.enq_pc;
        end
    end

    initial begin
        logic [31:0] p;
        bus.rsp_valid = 1'b0;
        bus.rsp_data  = '0;
        bus.rsp_pc    = '0;
        forever begin
            @(posedge clk);
            #2;
            if (acc_s) icq.push_back(acc_pc);
            bus.rsp_valid = 1'b0;
            if (force_rsp) begin
                bus.rsp_valid = 1'b1;
                bus.rsp_pc    = 32'h0000_0BAD;
                bus.rsp_data  = 32'h0000_0BAD ^ KEY;
            end else if (rsp_en && icq.size() > 0) begin
                p = icq.pop_front();
                bus.rsp_valid = 1'b1;
                bus.rsp_pc    = p;
                bus.rsp_data  = p ^ KEY;
            end
        end
    end

    // Reference model: queue contents and outstanding requests as PC lists.
    logic [31:0] m_iq[$];
    logic [31:0] m_if[$];
    bit          m_drain;
    logic [31:0] m_pc;
    logic [31:0] m_pend;
    bit          m_perr;

    always @(negedge clk) begin
        bit          e_rv;
        bit          e_ev;
        bit          acc;
        bit          rok;
        logic [31:0] front;
        if (!rst_n) begin
            m_iq.delete();
            m_if.delete();
            m_drain = 1'b0;
            m_pc    = RPC;
            m_pend  = '0;
            m_perr  = 1'b0;
        end else begin
            e_rv = !m_drain && !bus.redirect_valid
                   && (m_iq.size() + m_if.size() < DEPTH) && (m_if.size() < MAXIF);
            e_ev = !m_drain && !bus.redirect_valid && bus.rsp_valid && (m_if.size() > 0);
            chk("req_valid", 32'(bus.req_valid), 32'(e_rv));
            if (e_rv) chk("req_pc", bus.req_pc, m_pc);
            chk("enq_valid", 32'(bus.enq_valid), 32'(e_ev));
            if (e_ev) begin
                chk("enq_pc", bus.enq_pc, m_if[0]);
                chk("enq_data", bus.enq_data, m_if[0] ^ KEY);
            end
            chk("iq_flush", 32'(bus.iq_flush), 32'(bus.redirect_valid));
            chk("proto_err", 32'(bus.proto_err), 32'(m_perr));

            acc = e_rv && bus.req_ready;
            rok = bus.rsp_valid && (m_if.size() > 0);
            if (bus.rsp_valid && m_if.size() == 0) m_perr = 1'b1;
            front = '0;
            if (rok) front = m_if.pop_front();
            if (bus.redirect_valid) begin
                m_iq.delete();
                if (m_if.size() == 0) begin
                    m_drain = 1'b0;
                    m_pc    = bus.redirect_pc;
                end else begin
                    m_drain = 1'b1;
                    m_pend  = bus.redirect_pc;
                end
            end else if (m_drain) begin
                if (m_if.size() == 0) begin
                    m_drain = 1'b0;
                    m_pc    = m_pend;
                end
            end else begin
                if (bus.deq && m_iq.size() > 0) void'(m_iq.pop_front());
                if (rok) m_iq.push_back(front);
                if (acc) begin
                    m_if.push_back(m_pc);
                    m_pc = m_pc + 32'd4;
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int base_acc;
        int base_enq;
        rst_n              = 1'b0;
        bus.req_ready      = 1'b0;
        bus.deq            = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        cyc(3);
        rst_n = 1'b1;

        // Reset state
        @(negedge clk);
        chk("rst_req_valid", 32'(bus.req_valid), 32'd1);
        chk("rst_req_pc", bus.req_pc, 32'h0040_0000);
        chk("rst_proto_err", 32'(bus.proto_err), 32'd0);
        chk("rst_iq_flush", 32'(bus.iq_flush), 32'd0);
        cyc(1);

        // 1: stream until queue is full
        bus.req_ready = 1'b1;
        cyc(20);
        @(negedge clk);
        chk("t1_enq_count", 32'(n_enq), 32'd8);
        chk("t1_last_pc", last_enq_pc, 32'h0040_001C);
        chk("t1_req_stop", 32'(bus.req_valid), 32'd0);
        chk("t1_model_occ", 32'(m_iq.size()), 32'd8);
        cyc(1);

        // 2: one dequeue frees exactly one credit
        base_acc = n_acc;
        bus.deq = 1'b1;
        cyc(1);
        bus.deq = 1'b0;
        cyc(5);
        chk("t2_one_issue", 32'(n_acc - base_acc), 32'd1);

        // 3: stall holds request stable, then in-flight cap
        bus.req_ready = 1'b0;
        bus.deq = 1'b1;
        cyc(6);
        bus.deq = 1'b0;
        cyc(5);
        @(negedge clk);
        chk("t3_hold_valid", 32'(bus.req_valid), 32'd1);
        chk("t3_hold_pc", bus.req_pc, 32'h0040_0024);
        cyc(1);
        rsp_en = 1'b0;
        base_acc = n_acc;
        bus.req_ready = 1'b1;
        cyc(6);
        bus.req_ready = 1'b0;
        @(negedge clk);
        chk("t3_cap_count", 32'(n_acc - base_acc), 32'd4);
        chk("t3_cap_valid", 32'(bus.req_valid), 32'd0);
        cyc(1);

        // 4: redirect with 3 in flight
        rsp_en = 1'b1;
        cyc(1);
        rsp_en = 1'b0;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h0000_0500;
        @(negedge clk);
        chk("t4_flush", 32'(bus.iq_flush), 32'd1);
        chk("t4_model_if", 32'(m_if.size()), 32'd3);
        cyc(1);
        bus.redirect_valid = 1'b0;
        rsp_en = 1'b1;
        base_enq = n_enq;
        cyc(5);
        @(negedge clk);
        chk("t4_no_enq", 32'(n_enq - base_enq), 32'd0);
        chk("t4_restart_valid", 32'(bus.req_valid), 32'd1);
        chk("t4_restart_pc", bus.req_pc, 32'h0000_0500);
        cyc(1);

        // 5: redirect coincident with response and dequeue
        bus.req_ready = 1'b1;
        cyc(4);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h0000_0700;
        bus.deq            = 1'b1;
        @(negedge clk);
        chk("t5_no_enq", 32'(bus.enq_valid), 32'd0);
        cyc(1);
        bus.redirect_valid = 1'b0;
        bus.deq            = 1'b0;
        bus.req_ready      = 1'b0;
        @(negedge clk);
        chk("t5_model_occ", 32'(m_iq.size()), 32'd0);
        chk("t5_restart_pc", bus.req_pc, 32'h0000_0700);
        chk("t5_restart_valid", 32'(bus.req_valid), 32'd1);
        cyc(1);

        // 6: second redirect during drain wins; stray response flags proto_err
        bus.req_ready = 1'b1;
        rsp_en = 1'b0;
        cyc(2);
        bus.req_ready = 1'b0;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h0000_0500;
        cyc(1);
        bus.redirect_pc    = 32'h0000_0600;
        cyc(1);
        bus.redirect_valid = 1'b0;
        rsp_en = 1'b1;
        cyc(4);
        @(negedge clk);
        chk("t6_restart_pc", bus.req_pc, 32'h0000_0600);
        chk("t6_perr_clear", 32'(bus.proto_err), 32'd0);
        cyc(1);
        force_rsp = 1'b1;
        cyc(1);
        force_rsp = 1'b0;
        @(negedge clk);
        chk("t6_stray_no_enq", 32'(bus.enq_valid), 32'd0);
        chk("t6_proto_err", 32'(bus.proto_err), 32'd1);
        cyc(3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
